// File: rtl/adc_pkg.sv
// Shared constants and select decoding for the dual-slope ADC front end.
// The integration count must match the wrap of the controller's counter, so
// the number of reference steps to reach zero equals the input code.
package adc_pkg;

    // Reference de-integration step per clock, in mV.
    localparam int VREF_MV        = 1000;
    // Integration phase length in clocks.
    localparam int N_INT          = 1000;
    // Largest input code the converter is specified for.
    localparam int VM_MAX         = 999;
    // Worst-case accumulator value after a full integration phase.
    localparam int ACC_FULL_SCALE = VM_MAX * N_INT;
    // Smallest accumulator width that holds a full-scale integration.
    localparam int ACC_W_MIN      = $clog2(ACC_FULL_SCALE + 1);
    // Width of the input code.
    localparam int VM_W_MIN       = $clog2(VM_MAX + 1);

    // What the integrator does on a given edge.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_ZERO  = 2'd1,
        OP_INT   = 2'd2,
        OP_DEINT = 2'd3
    } op_t;

    // Priority decode of the three switch selects: auto-zero wins over
    // integrate, which wins over de-integrate.
    function automatic op_t select_op(input logic zr, input logic vm, input logic rf);
        op_t op;
        op = OP_HOLD;
        if (zr)
            op = OP_ZERO;
        else if (vm)
            op = OP_INT;
        else if (rf)
            op = OP_DEINT;
        return op;
    endfunction

    // True when two or more selects are asserted at once (switch conflict).
    function automatic logic multi_select(input logic zr, input logic vm, input logic rf);
        return (zr & vm) | (zr & rf) | (vm & rf);
    endfunction

endpackage

// File: rtl/somador_saturado.sv
// W-bit unsigned add/subtract that clamps at 0 and 2^W-1 instead of wrapping.
// sat flags that the clamp was applied (carry on add, borrow on subtract).
module somador_saturado #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         sat
);

    logic [W:0] ext;

    // One extra bit catches both carry-out and borrow; the clamp direction
    // follows the operation.
    always_comb begin
        ext = '0;
        y   = '0;
        sat = 1'b0;
        if (sub)
            ext = {1'b0, a} - {1'b0, b};
        else
            ext = {1'b0, a} + {1'b0, b};

        if (ext[W]) begin
            sat = 1'b1;
            y   = sub ? '0 : '1;
        end else begin
            y   = ext[W-1:0];
        end
    end

endmodule

// File: rtl/integrador_dupla_rampa.sv
// Cycle-accurate model of the dual-slope integrator and zero-crossing
// comparator. Integrates vm_in while ch_vm is high, removes VREF per clock
// while ch_ref is high, and emits a one-clock Vint_z pulse when the
// accumulator reaches zero. The pulse fires once per integration phase:
// 'armed' is set by integration and consumed by the zero crossing.
module integrador_dupla_rampa
    import adc_pkg::*;
#(
    parameter int VM_W  = VM_W_MIN,
    parameter int ACC_W = ACC_W_MIN,
    parameter int VREF  = VREF_MV
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             ch_zr,
    input  logic             ch_vm,
    input  logic             ch_ref,
    input  logic [VM_W-1:0]  vm_in,
    output logic             Vint_z,
    output logic             ovf,
    output logic             sel_err,
    output logic [ACC_W-1:0] acc_mon
);

    localparam logic [ACC_W-1:0] VREF_STEP = ACC_W'(VREF);

    logic [ACC_W-1:0] acc_reg;
    logic             armed_reg;
    logic             vint_z_reg;
    logic             ovf_reg;
    logic             sel_err_reg;

    op_t              op;
    logic [ACC_W-1:0] operand;
    logic [ACC_W-1:0] acc_next;
    logic             acc_sat;
    logic             at_zero;

    // Decode the switches once; everything below keys off this.
    always_comb begin
        op      = select_op(ch_zr, ch_vm, ch_ref);
        operand = (op == OP_DEINT) ? VREF_STEP : ACC_W'(vm_in);
        // Comparator trip: the remaining charge fits inside one reference step.
        at_zero = (acc_reg <= VREF_STEP);
    end

    somador_saturado #(
        .W (ACC_W)
    ) u_somador (
        .a   (acc_reg),
        .b   (operand),
        .sub (op == OP_DEINT),
        .y   (acc_next),
        .sat (acc_sat)
    );

    // Integrator, arming flag, zero-crossing pulse and sticky saturation flag.
    always_ff @(posedge ck) begin
        if (rst) begin
            acc_reg     <= '0;
            armed_reg   <= 1'b0;
            vint_z_reg  <= 1'b0;
            ovf_reg     <= 1'b0;
            sel_err_reg <= 1'b0;
        end else begin
            sel_err_reg <= multi_select(ch_zr, ch_vm, ch_ref);
            vint_z_reg  <= 1'b0;
            case (op)
                OP_ZERO: begin
                    acc_reg   <= '0;
                    armed_reg <= 1'b0;
                    ovf_reg   <= 1'b0;
                end
                OP_INT: begin
                    acc_reg   <= acc_next;
                    armed_reg <= 1'b1;
                    if (acc_sat)
                        ovf_reg <= 1'b1;
                end
                OP_DEINT: begin
                    // Once disarmed the comparator stays quiet and the
                    // accumulator holds until the next integration.
                    if (armed_reg) begin
                        if (at_zero) begin
                            acc_reg    <= '0;
                            vint_z_reg <= 1'b1;
                            armed_reg  <= 1'b0;
                        end else begin
                            acc_reg    <= acc_next;
                        end
                    end
                end
                default: begin
                    // Ideal integrator: no droop while idle.
                end
            endcase
        end
    end

    assign Vint_z  = vint_z_reg;
    assign ovf     = ovf_reg;
    assign sel_err = sel_err_reg;
    assign acc_mon = acc_reg;

endmodule

// File: tb/tb_integrador_dupla_rampa.sv
// Bench for integrador_dupla_rampa. Two instances share stimulus: the
// full-width converter and a 12-bit one used to exercise saturation.
// Expected values come from constants, the latency rule and a behavioural
// integer model of the integrator.
module tb_integrador_dupla_rampa;

    localparam int VM_W = 10;
    localparam int VREF = 1000;

    logic        ck = 1'b0;
    logic        rst;
    logic        ch_zr;
    logic        ch_vm;
    logic        ch_ref;
    logic [9:0]  vm_in;

    logic        vz0, ovf0, se0;
    logic [19:0] acc0;
    logic        vz1, ovf1, se1;
    logic [11:0] acc1;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model, index 0 = 20-bit instance, 1 = 12-bit instance.
    longint m_acc[2];
    bit     m_arm[2];
    bit     m_vz[2];
    bit     m_ovf[2];
    bit     m_se;
    longint m_max[2];

    always #5 ck = ~ck;

    integrador_dupla_rampa #(.VM_W(VM_W), .ACC_W(20), .VREF(VREF)) dut (
        .ck(ck), .rst(rst), .ch_zr(ch_zr), .ch_vm(ch_vm), .ch_ref(ch_ref),
        .vm_in(vm_in), .Vint_z(vz0), .ovf(ovf0), .sel_err(se0), .acc_mon(acc0)
    );

    integrador_dupla_rampa #(.VM_W(VM_W), .ACC_W(12), .VREF(VREF)) dut_small (
        .ck(ck), .rst(rst), .ch_zr(ch_zr), .ch_vm(ch_vm), .ch_ref(ch_ref),
        .vm_in(vm_in), .Vint_z(vz1), .ovf(ovf1), .sel_err(se1), .acc_mon(acc1)
    );

    task automatic model_step();
        int nsel;
        nsel = int'(ch_zr) + int'(ch_vm) + int'(ch_ref);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_acc[i] = 0; m_arm[i] = 0; m_vz[i] = 0; m_ovf[i] = 0;
            end else begin
                m_vz[i] = 0;
                if (ch_zr) begin
                    m_acc[i] = 0; m_arm[i] = 0; m_ovf[i] = 0;
                end else if (ch_vm) begin
                    m_acc[i] = m_acc[i] + longint'(vm_in);
                    if (m_acc[i] > m_max[i]) begin
                        m_acc[i] = m_max[i];
                        m_ovf[i] = 1;
                    end
                    m_arm[i] = 1;
                end else if (ch_ref && m_arm[i]) begin
                    if (m_acc[i] <= VREF) begin
                        m_acc[i] = 0; m_vz[i] = 1; m_arm[i] = 0;
                    end else begin
                        m_acc[i] = m_acc[i] - VREF;
                    end
                end
            end
        end
        m_se = rst ? 1'b0 : (nsel >= 2);
    endtask

    // Advance one clock; the model sees the same inputs the DUT sampled.
    task automatic tick();
        @(posedge ck);
        model_step();
        #1;
    endtask

    task automatic set_sel(input bit zr, input bit vm, input bit rf);
        ch_zr = zr; ch_vm = vm; ch_ref = rf;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_sel(0, 1, 0); vm_in = 10'd500;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (acc0 !== 20'd0 || vz0 !== 1'b0 || ovf0 !== 1'b0 || se0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: acc=%0d vz=%b ovf=%b se=%b, want 0 0 0 0", c, acc0, vz0, ovf0, se0);
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (acc0 !== 20'd500) begin
            errors++;
            $display("FAIL reset_release: acc=%0d want 500", acc0);
        end
        $display("reset: held 3 cycles, first integrate acc=%0d", acc0);
    endtask

    // Full conversion: auto-zero, integrate 1000 clocks, de-integrate and
    // count edges to the pulse.
    task automatic test_conversion(input int vm);
        int k_exp, k_got, extra;
        set_sel(1, 0, 0); tick();
        vm_in = 10'(vm); set_sel(0, 1, 0);
        for (int c = 0; c < 1000; c++) tick();
        vectors++;
        if (acc0 !== 20'(vm * 1000)) begin
            errors++;
            $display("FAIL conv_integrate vm=%0d: acc=%0d want %0d", vm, acc0, vm * 1000);
        end
        k_exp = (vm * 1000 + VREF - 1) / VREF;
        if (k_exp < 1) k_exp = 1;
        set_sel(0, 0, 1);
        k_got = -1;
        for (int e = 1; e <= k_exp + 50 && k_got < 0; e++) begin
            tick();
            if (vz0 === 1'b1) k_got = e;
        end
        vectors++;
        if (k_got != k_exp) begin
            errors++;
            $display("FAIL conv_latency vm=%0d: pulse after edge %0d want %0d", vm, k_got, k_exp);
        end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (vz0 !== 1'b0) extra++;
        end
        vectors++;
        if (extra != 0 || acc0 !== 20'd0) begin
            errors++;
            $display("FAIL conv_after vm=%0d: extra pulses=%0d acc=%0d want 0 0", vm, extra, acc0);
        end
        set_sel(0, 0, 0); tick();
        $display("conversion vm=%0d: pulse after edge %0d (expected %0d)", vm, k_got, k_exp);
    endtask

    task automatic test_saturation();
        set_sel(1, 0, 0); tick();
        vm_in = 10'd999; set_sel(0, 1, 0);
        for (int c = 0; c < 10; c++) tick();
        vectors++;
        if (acc1 !== 12'd4095 || ovf1 !== 1'b1 || acc0 !== 20'd9990 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL sat_integrate: small acc=%0d ovf=%b, big acc=%0d ovf=%b; want 4095 1 9990 0", acc1, ovf1, acc0, ovf0);
        end
        // Sticky through idle and de-integration; still pulses.
        set_sel(0, 0, 1);
        for (int c = 0; c < 5; c++) tick();
        vectors++;
        if (ovf1 !== 1'b1 || vz1 !== 1'b1 || acc1 !== 12'd0) begin
            errors++;
            $display("FAIL sat_sticky: ovf=%b vz=%b acc=%0d want 1 1 0", ovf1, vz1, acc1);
        end
        set_sel(1, 0, 0); tick();
        vectors++;
        if (ovf1 !== 1'b0 || acc1 !== 12'd0) begin
            errors++;
            $display("FAIL sat_clear: ovf=%b acc=%0d want 0 0", ovf1, acc1);
        end
        set_sel(0, 0, 0);
        $display("saturation: 12-bit clamps at 4095, ovf cleared by auto-zero");
    endtask

    task automatic test_sel_conflict();
        set_sel(1, 0, 0); tick();
        vm_in = 10'd40; set_sel(0, 1, 0); tick();
        vm_in = 10'd7;  set_sel(0, 1, 1); tick();
        vectors++;
        if (acc0 !== 20'd47 || se0 !== 1'b1) begin
            errors++;
            $display("FAIL sel_vm_ref: acc=%0d se=%b want 47 1", acc0, se0);
        end
        set_sel(0, 0, 0); tick();
        vectors++;
        if (se0 !== 1'b0 || acc0 !== 20'd47) begin
            errors++;
            $display("FAIL sel_clear: se=%b acc=%0d want 0 47", se0, acc0);
        end
        set_sel(1, 1, 0); tick();
        vectors++;
        if (acc0 !== 20'd0 || se0 !== 1'b1) begin
            errors++;
            $display("FAIL sel_zr_vm: acc=%0d se=%b want 0 1", acc0, se0);
        end
        set_sel(0, 0, 0); tick();
        $display("select conflict: vm wins over ref, zr wins over vm");
    endtask

    // Partial de-integration, pause, re-integration and resume.
    task automatic test_pause_resume();
        int k_got;
        set_sel(1, 0, 0); tick();
        vm_in = 10'd250; set_sel(0, 1, 0);
        for (int c = 0; c < 20; c++) tick();      // 5000
        set_sel(0, 0, 1); tick(); tick();          // 3000
        set_sel(0, 0, 0); for (int c = 0; c < 4; c++) tick();
        vectors++;
        if (acc0 !== 20'd3000) begin
            errors++;
            $display("FAIL pause_hold: acc=%0d want 3000", acc0);
        end
        vm_in = 10'd500; set_sel(0, 1, 0); tick();  // 3500
        vectors++;
        if (acc0 !== 20'd3500) begin
            errors++;
            $display("FAIL reintegrate: acc=%0d want 3500", acc0);
        end
        set_sel(0, 0, 1);
        k_got = -1;
        for (int e = 1; e <= 20 && k_got < 0; e++) begin
            tick();
            if (vz0 === 1'b1) k_got = e;
        end
        vectors++;
        if (k_got != 4) begin
            errors++;
            $display("FAIL resume_latency: pulse after edge %0d want 4", k_got);
        end
        set_sel(0, 0, 0); tick();
        $display("pause/resume: pulse after edge %0d", k_got);
    endtask

    task automatic test_rst_midphase();
        set_sel(1, 0, 0); tick();
        vm_in = 10'd900; set_sel(0, 1, 0);
        for (int c = 0; c < 8; c++) tick();
        rst = 1'b1; set_sel(0, 0, 1); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        vectors++;
        if (acc0 !== 20'd0 || vz0 !== 1'b0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_midphase: acc=%0d vz=%b ovf_small=%b want 0 0 0", acc0, vz0, ovf1);
        end
        set_sel(0, 0, 0);
        $display("reset mid-phase: disarmed, acc=%0d", acc0);
    endtask

    // Random selects and codes, every cycle compared against the model.
    task automatic test_random();
        int bad;
        int r;
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            rst    = (r == 0);
            ch_zr  = ($urandom_range(0, 99) < 2);
            ch_vm  = ($urandom_range(0, 99) < 45);
            ch_ref = ($urandom_range(0, 99) < 60);
            vm_in  = 10'($urandom_range(0, 999));
            tick();
            vectors++;
            if (acc0 !== 20'(m_acc[0]) || vz0 !== m_vz[0] || ovf0 !== m_ovf[0] || se0 !== m_se ||
                acc1 !== 12'(m_acc[1]) || vz1 !== m_vz[1] || ovf1 !== m_ovf[1] || se1 !== m_se) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cycle %0d: acc=%0d/%0d vz=%b/%b ovf=%b/%b se=%b/%b want acc=%0d/%0d vz=%b/%b ovf=%b/%b se=%b",
                             c, acc0, acc1, vz0, vz1, ovf0, ovf1, se0, se1,
                             m_acc[0], m_acc[1], m_vz[0], m_vz[1], m_ovf[0], m_ovf[1], m_se);
            end
        end
        rst = 1'b0; set_sel(0, 0, 0);
        $display("random: 3000 cycles, %0d bad", bad);
    endtask

    initial begin
        m_max[0] = (64'd1 << 20) - 1;
        m_max[1] = (64'd1 << 12) - 1;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_arm[i] = 0; m_vz[i] = 0; m_ovf[i] = 0;
        end
        m_se = 0;
        rst = 1'b1; ch_zr = 0; ch_vm = 0; ch_ref = 0; vm_in = '0;

        test_reset();
        test_conversion(300);
        test_conversion(0);
        test_conversion(999);
        test_conversion(1);
        test_conversion(int'($urandom_range(2, 998)));
        test_saturation();
        test_sel_conflict();
        test_pause_resume();
        test_rst_midphase();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
